// File: rtl/vault_access_scheduler.sv
// Minute-of-day clock, business-hours window and vault access sequencer.
// Gates the safe's open action and enforces a lockout after repeated bad PINs.
module vault_access_scheduler #(
  parameter int TICK_DIV      = 100000000,
  parameter int OPEN_MIN      = 540,
  parameter int CLOSE_MIN     = 1020,
  parameter int AUTH_MIN      = 2,
  parameter int AUTO_LOCK_MIN = 30,
  parameter int MAX_FAIL      = 3,
  parameter int LOCKOUT_MIN   = 60
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        TimeSet_i,
  input  logic [10:0] TimeSetValue_i,
  input  logic        OpenReq_i,
  input  logic        CloseReq_i,
  input  logic        AuthGrant_i,
  input  logic        PINInvalid_i,
  output logic        BankTiming_o,
  output logic        VaultEnable_o,
  output logic        LockoutLED_o,
  output logic [10:0] MinuteOfDay_o,
  output logic [2:0]  State_o
);

  // state     | meaning
  // OFFHOURS  | outside business hours, vault closed
  // IDLE      | in hours, waiting for an open request
  // WAIT_AUTH | open requested, waiting for authentication grant
  // OPEN      | safe may open, auto-relock timer running
  // LOCKOUT   | too many invalid PINs, requests ignored
  typedef enum logic [2:0] {
    S_OFFHOURS  = 3'd0,
    S_IDLE      = 3'd1,
    S_WAIT_AUTH = 3'd2,
    S_OPEN      = 3'd3,
    S_LOCKOUT   = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = 16;

  logic [PW-1:0] presc_q, presc_d;
  logic [10:0]   minute_q, minute_d;
  logic          bank_q, bank_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] fail_q, fail_d;
  logic          ven_q, lock_q;

  logic tick_w, ts_ok_w;
  logic auth_exp_w, open_exp_w, lock_exp_w;
  logic fail_hit_w;
  logic [FW-1:0] fail_inc_w;

  assign tick_w  = (presc_q == PW'(TICK_DIV - 1));
  assign ts_ok_w = TimeSet_i && (TimeSetValue_i <= 11'd1439);

  always_comb begin
    presc_d  = presc_q + PW'(1);
    minute_d = minute_q;
    if (ts_ok_w) begin
      presc_d  = '0;
      minute_d = TimeSetValue_i;
    end else if (tick_w) begin
      presc_d  = '0;
      minute_d = (minute_q == 11'd1439) ? 11'd0 : minute_q + 11'd1;
    end
  end

  assign bank_d = (minute_q >= 11'(OPEN_MIN)) && (minute_q < 11'(CLOSE_MIN));

  // timer counts completed ticks in the current state; expiry is the tick that reaches the limit
  assign auth_exp_w = tick_w && (timer_q == TW'(AUTH_MIN - 1));
  assign open_exp_w = tick_w && (timer_q == TW'(AUTO_LOCK_MIN - 1));
  assign lock_exp_w = tick_w && (timer_q == TW'(LOCKOUT_MIN - 1));

  assign fail_hit_w = (fail_q == FW'(MAX_FAIL - 1));
  assign fail_inc_w = (fail_q >= FW'(MAX_FAIL)) ? FW'(MAX_FAIL) : fail_q + FW'(1);

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    case (state_q)
      S_OFFHOURS: begin
        if (bank_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!bank_q)        state_d = S_OFFHOURS;
        else if (OpenReq_i) state_d = S_WAIT_AUTH;
      end
      S_WAIT_AUTH: begin
        if (!bank_q) begin
          state_d = S_OFFHOURS;
        end else if (PINInvalid_i && fail_hit_w) begin
          state_d = S_LOCKOUT;
          fail_d  = fail_inc_w;
        end else if (AuthGrant_i) begin
          state_d = S_OPEN;
          fail_d  = '0;
        end else if (auth_exp_w) begin
          state_d = fail_hit_w ? S_LOCKOUT : S_IDLE;
          fail_d  = fail_inc_w;
        end else if (PINInvalid_i) begin
          fail_d  = fail_inc_w;
        end
      end
      S_OPEN: begin
        if (!bank_q)                                      state_d = S_OFFHOURS;
        else if (CloseReq_i || !AuthGrant_i || open_exp_w) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (lock_exp_w) begin
          state_d = S_OFFHOURS;
          fail_d  = '0;
        end
      end
      default: state_d = S_OFFHOURS;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)            timer_d = '0;
    else if (tick_w && timer_q != '1)  timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      presc_q  <= '0;
      minute_q <= '0;
      bank_q   <= 1'b0;
      state_q  <= S_OFFHOURS;
      timer_q  <= '0;
      fail_q   <= '0;
      ven_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      minute_q <= minute_d;
      bank_q   <= bank_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      ven_q    <= (state_d == S_OPEN);
      lock_q   <= (state_d == S_LOCKOUT);
    end
  end

  assign BankTiming_o  = bank_q;
  assign VaultEnable_o = ven_q;
  assign LockoutLED_o  = lock_q;
  assign MinuteOfDay_o = minute_q;
  assign State_o       = state_q;

endmodule

// File: tb/tb_vault_access_scheduler.sv
// Scoreboard bench for vault_access_scheduler: a behavioural model predicts outputs
// per edge, and a negedge monitor pops and compares them.
module tb_vault_access_scheduler;

  localparam int TD    = 4;
  localparam int OPENM = 540;
  localparam int CLOSM = 1020;
  localparam int AUTHM = 2;
  localparam int AUTOM = 30;
  localparam int MAXF  = 3;
  localparam int LOCKM = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, ts = 1'b0, open_r = 1'b0, close_r = 1'b0, grant = 1'b0, pin = 1'b0;
  logic [10:0] tsv = '0;
  logic        bank, ven, lock;
  logic [10:0] minute;
  logic [2:0]  st;

  vault_access_scheduler #(
    .TICK_DIV(TD), .OPEN_MIN(OPENM), .CLOSE_MIN(CLOSM), .AUTH_MIN(AUTHM),
    .AUTO_LOCK_MIN(AUTOM), .MAX_FAIL(MAXF), .LOCKOUT_MIN(LOCKM)
  ) dut (
    .Clk_i(clk), .Reset_i(rst_n), .TimeSet_i(ts), .TimeSetValue_i(tsv),
    .OpenReq_i(open_r), .CloseReq_i(close_r), .AuthGrant_i(grant), .PINInvalid_i(pin),
    .BankTiming_o(bank), .VaultEnable_o(ven), .LockoutLED_o(lock),
    .MinuteOfDay_o(minute), .State_o(st)
  );

  typedef struct {
    int tgt;
    int minute;
    bit bank;
    int st;
    bit ven;
    bit lock;
  } exp_t;

  exp_t sbq[$];
  int   edge_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference model: clock as cycle/minute arithmetic, sequencer as ticks-in-state plus fail count
  int m_presc = 0, m_min = 0, m_st = 0, m_ticks = 0, m_fail = 0;
  bit m_bank = 0;
  bit g_lvl = 0;

  always @(posedge clk) edge_cnt++;

  task automatic model_step(input bit r, input bit t, input int tv,
                            input bit o, input bit c, input bit g, input bit p);
    bit tick, expire;
    int ns, nf, el, lim;
    if (!r) begin
      m_presc = 0; m_min = 0; m_bank = 0; m_st = 0; m_ticks = 0; m_fail = 0;
      return;
    end
    tick = (m_presc == TD - 1);
    el   = m_ticks + (tick ? 1 : 0);
    lim  = (m_st == 2) ? AUTHM : (m_st == 3) ? AUTOM : LOCKM;
    expire = tick && (el == lim);
    ns = m_st;
    nf = m_fail;
    case (m_st)
      0: if (m_bank) ns = 1;
      1: if (!m_bank) ns = 0; else if (o) ns = 2;
      2: begin
        if (!m_bank) ns = 0;
        else if (p && m_fail + 1 == MAXF) begin ns = 4; nf = MAXF; end
        else if (g) begin ns = 3; nf = 0; end
        else if (expire) begin
          nf = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
          ns = (m_fail + 1 == MAXF) ? 4 : 1;
        end
        else if (p) nf = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
      end
      3: if (!m_bank) ns = 0; else if (c || !g || expire) ns = 1;
      4: if (expire) begin ns = 0; nf = 0; end
      default: ns = 0;
    endcase
    m_ticks = (ns != m_st) ? 0 : el;
    m_st    = ns;
    m_fail  = nf;
    m_bank  = (m_min >= OPENM) && (m_min < CLOSM);
    if (t && tv < 1440) begin
      m_min = tv; m_presc = 0;
    end else begin
      if (tick) m_min = (m_min + 1) % 1440;
      m_presc = (m_presc + 1) % TD;
    end
  endtask

  task automatic drive(input bit r, input bit t, input int tv,
                       input bit o, input bit c, input bit g, input bit p);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; ts = t; tsv = 11'(tv); open_r = o; close_r = c; grant = g; pin = p;
    model_step(r, t, tv, o, c, g, p);
    e.tgt = edge_cnt + 1;
    e.minute = m_min;
    e.bank = m_bank;
    e.st = m_st;
    e.ven = (m_st == 3);
    e.lock = (m_st == 4);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, g_lvl, 0);
  endtask

  task automatic set_time(input int v);
    drive(1, 1, v, 0, 0, g_lvl, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].tgt <= edge_cnt) begin
      e = sbq.pop_front();
      checks++;
      if (minute !== 11'(e.minute) || bank !== e.bank || st !== 3'(e.st) ||
          ven !== e.ven || lock !== e.lock) begin
        errors++;
        $display("FAIL outputs@edge%0d: got min=%0d bank=%0b st=%0d ven=%0b lock=%0b, want min=%0d bank=%0b st=%0d ven=%0b lock=%0b",
                 e.tgt, minute, bank, st, ven, lock, e.minute, e.bank, e.st, e.ven, e.lock);
      end
    end
  end

  initial begin
    // reset and free-running clock, wrap at midnight
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
    idle(8);
    set_time(1439);
    idle(4);
    // enter business hours
    set_time(539);
    idle(6);
    // open with grant, then close
    drive(1, 0, 0, 1, 0, 0, 0);
    idle(1);
    g_lvl = 1;
    idle(4);
    drive(1, 0, 0, 0, 1, 1, 0);
    idle(3);
    // auto-relock with grant held
    drive(1, 0, 0, 1, 0, 1, 0);
    idle(AUTOM * TD + 8);
    g_lvl = 0;
    idle(2);
    // three bad PINs, lockout, request ignored, lockout expiry
    drive(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 1);
    idle(2);
    drive(1, 0, 0, 1, 0, 1, 0);
    drive(1, 1, 700, 0, 0, 0, 0);
    idle(LOCKM * TD + 8);
    // leave hours while open, then an out-of-range time set
    drive(1, 0, 0, 1, 0, 0, 0);
    g_lvl = 1;
    idle(4);
    set_time(1020);
    idle(4);
    set_time(2000);
    idle(3);
    // reset while open
    set_time(600);
    idle(3);
    drive(1, 0, 0, 1, 0, 1, 0);
    idle(3);
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    g_lvl = 0;
    // randomized traffic
    set_time(540);
    for (int i = 0; i < 2500; i++) begin
      bit t, r;
      int v, sel;
      t   = ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 999) != 0);
      sel = $urandom_range(0, 3);
      v   = (sel == 0) ? $urandom_range(0, 1439) :
            (sel == 1) ? $urandom_range(530, 560) :
            (sel == 2) ? $urandom_range(1010, 1030) : $urandom_range(1440, 2047);
      if ($urandom_range(0, 14) == 0) g_lvl = !g_lvl;
      drive(r, t, v, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
            g_lvl, $urandom_range(0, 24) == 0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vault_access_scheduler.md
Name: vault_access_scheduler

Overview:
- Time-of-day scheduler and access sequencer for the bank vault.
- Keeps a minute-of-day clock and generates the BankTiming business-hours window consumed by the authentication module.
- Sequences open/close requests against the authentication grant (VaultStatus), applies an auto-relock timeout, and enforces a lockout after repeated invalid PIN attempts.
- Sits between the top level and the authentication/safe modules. VaultEnable gates the safe's open action.

Parameters:
- TICK_DIV, 100000000: Clk cycles per minute tick (benches use 4).
- OPEN_MIN, 540: first minute of business hours (09:00).
- CLOSE_MIN, 1020: first minute after business hours (17:00). Requires OPEN_MIN < CLOSE_MIN ≤ 1440.
- AUTH_MIN, 2: minute ticks allowed in WAIT_AUTH before abandoning.
- AUTO_LOCK_MIN, 30: minute ticks the vault may stay open.
- MAX_FAIL, 3: invalid attempts that trigger lockout.
- LOCKOUT_MIN, 60: lockout duration in minute ticks.

Ports:
- Clk, input, 1: system clock.
- Reset, input, 1: synchronous, active-low reset.
- TimeSet, input, 1: one-cycle pulse; loads TimeSetValue.
- TimeSetValue, input, 11: minute of day, 0..1439.
- OpenReq, input, 1: one-cycle open request pulse (debounced push).
- CloseReq, input, 1: one-cycle close request pulse.
- AuthGrant, input, 1: level; VaultStatus from authentication.
- PINInvalid, input, 1: one-cycle pulse per rejected PIN (safe InvalidLED rising edge).
- BankTiming, output, 1: high when OPEN_MIN ≤ MinuteOfDay < CLOSE_MIN.
- VaultEnable, output, 1: safe may open.
- LockoutLED, output, 1: lockout active.
- MinuteOfDay, output, 11: current minute.
- State, output, 3: FSM state code, for VIO probing.

Behaviour:
- Reset (Reset=0 at a Clk edge):
  - Prescaler=0, MinuteOfDay=0, BankTiming=0, VaultEnable=0, LockoutLED=0, State=OFFHOURS(0).
  - Fail counter=0, timers=0.
- Prescaler:
  - Counts 0..TICK_DIV-1. Tick is a one-cycle strobe when the count equals TICK_DIV-1, then the count wraps to 0.
- MinuteOfDay:
  - Increments on tick; wraps 1439→0.
  - TimeSet has priority over tick. It loads TimeSetValue and clears the prescaler.
  - TimeSetValue > 1439 is ignored entirely (no load, no prescaler clear).
- BankTiming:
  - Registered compare of MinuteOfDay.
  - Valid one cycle after MinuteOfDay changes.
- State encoding: OFFHOURS=0, IDLE=1, WAIT_AUTH=2, OPEN=3, LOCKOUT=4.
- Timer:
  - One minute-tick counter, cleared on every state change.
  - Expiry means the counter reaches the state's limit on a tick.
- VaultEnable=1 only in OPEN. LockoutLED=1 only in LOCKOUT. Both are registered with the state.
- Transitions are evaluated per cycle; the first matching row wins.
- OFFHOURS:
  - BankTiming=1 → IDLE.
- IDLE:
  - BankTiming=0 → OFFHOURS.
  - OpenReq → WAIT_AUTH.
- WAIT_AUTH:
  - BankTiming=0 → OFFHOURS.
  - PINInvalid and fail+1 == MAX_FAIL → LOCKOUT.
  - AuthGrant=1 → OPEN (fail cleared).
  - Timer == AUTH_MIN → IDLE, fail+1. If fail+1 == MAX_FAIL, go to LOCKOUT instead.
  - PINInvalid below the threshold: fail+1, stay in WAIT_AUTH.
- OPEN:
  - BankTiming=0 → OFFHOURS.
  - CloseReq, AuthGrant=0, or timer == AUTO_LOCK_MIN → IDLE.
- LOCKOUT:
  - Ignores OpenReq, AuthGrant, BankTiming and TimeSet for state purposes. TimeSet still updates the clock.
  - Timer == LOCKOUT_MIN → OFFHOURS, fail cleared. OFFHOURS re-enters IDLE next cycle if in hours.
- Counter rules:
  - Fail counter saturates at MAX_FAIL.
  - Fail counter persists across IDLE and OFFHOURS.
  - Fail counter is cleared only by OPEN entry, lockout exit or reset.
- Simultaneous events:
  - OpenReq and CloseReq together in IDLE → WAIT_AUTH (CloseReq has no meaning there).
  - PINInvalid and AuthGrant together in WAIT_AUTH → the lockout check wins when it hits the threshold; otherwise OPEN and the invalid is discarded.
- Reset mid-OPEN: VaultEnable falls at that same edge.

Test Plan:
- Reset, TICK_DIV=4 → all outputs 0, State=0. After 8 cycles MinuteOfDay=2. TimeSet=1439, then 4 cycles → MinuteOfDay=0.
- TimeSet=539, wait 1 tick → MinuteOfDay=540. BankTiming=1 one cycle later. State=1 the cycle after that.
- In IDLE: OpenReq, AuthGrant=1 two cycles later → State=3, VaultEnable=1. CloseReq → State=1, VaultEnable=0 next edge.
- In OPEN hold AuthGrant=1, no CloseReq for AUTO_LOCK_MIN ticks → returns to IDLE exactly on the 30th tick.
- In WAIT_AUTH: 3 PINInvalid pulses → State=4, LockoutLED=1. OpenReq ignored. After 60 ticks → OFFHOURS then IDLE, fail=0.
- In OPEN: TimeSet=1020 → BankTiming=0, State=0, VaultEnable=0. TimeSet=2000 → MinuteOfDay unchanged.
